// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants and types for the note parser slice.
package midi_pkg;
    localparam logic [3:0] NOTE_OFF    = 4'h8;
    localparam logic [3:0] NOTE_ON     = 4'h9;
    localparam logic [7:0] SYS_RT_MIN  = 8'hF8;
    localparam logic [7:0] SYS_COM_MIN = 8'hF0;
    localparam logic [6:0] KEY_EMPTY   = 7'd0;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    typedef logic data_idx_t;
endpackage

// File: rtl/midi_note_parser_if.sv
// midi_note_parser_if: MIDI serial line in, held-key indices and strobes out.
interface midi_note_parser_if;
    logic       serial;
    logic       ready;
    logic       framing_err;
    logic [6:0] key1_index;
    logic [6:0] key2_index;

    modport master (output serial, input ready, framing_err, key1_index, key2_index);
    modport slave  (input serial, output ready, framing_err, key1_index, key2_index);
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 2-flop synchronizer plus 8N1 UART receiver at BAUD.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 65000000,
    parameter int BAUD   = 31250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_serial,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_framing_err
);
    localparam logic [15:0] BIT_CYC = 16'(CLK_HZ / BAUD);
    localparam logic [15:0] HALF    = BIT_CYC / 16'd2;

    uart_state_t r_state;
    logic [1:0]  r_sync;
    logic        r_prev;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        r_ferr;
    logic        w_rx;

    assign w_rx          = r_sync[1];
    assign o_byte        = r_shift;
    assign o_byte_valid  = r_valid;
    assign o_framing_err = r_ferr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_serial};
            r_prev  <= w_rx;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_cnt   <= r_cnt + 16'd1;
            case (r_state)
                IDLE: begin
                    r_cnt <= 16'd0;
                    if (r_prev && !w_rx) r_state <= START;
                end
                START: if (r_cnt == HALF - 16'd1) begin
                    r_cnt   <= 16'd0;
                    r_bit   <= 3'd0;
                    r_state <= w_rx ? IDLE : DATA;
                end
                DATA: if (r_cnt == BIT_CYC - 16'd1) begin
                    r_cnt   <= 16'd0;
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                    if (r_bit == 3'd7) r_state <= STOP;
                end
                STOP: if (r_cnt == BIT_CYC - 16'd1) begin
                    // back to IDLE at mid-stop so a back-to-back start bit is seen
                    r_valid <= w_rx;
                    r_ferr  <= !w_rx;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/midi_note_parser.sv
// midi_note_parser: MIDI running-status parser tracking two held keys.
// Optional MIDI_CHANNEL_FILTER_EN: only note events on CHANNEL change the keys.
module midi_note_parser
    import midi_pkg::*;
#(
    parameter int CLK_HZ  = 65000000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0
) (
    input logic               clock,
    input logic               reset,
    midi_note_parser_if.slave bus
);
`ifdef MIDI_CHANNEL_FILTER_EN
    localparam logic [3:0] CH_MASK = 4'hF;
`else
    localparam logic [3:0] CH_MASK = 4'h0;
`endif

    logic [7:0] w_byte;
    logic       w_valid;
    logic       w_ferr;
    logic [7:0] r_status;
    data_idx_t  r_idx;
    logic [6:0] r_note;
    logic [6:0] r_key1;
    logic [6:0] r_key2;
    logic       r_ready;
    logic       w_note_st;
    logic       w_ch_ok;
    logic       w_exec;
    logic       w_on;
    logic       w_has;
    logic [6:0] w_k1;
    logic [6:0] w_k2;

    midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clock         (clock),
        .reset         (reset),
        .i_serial      (bus.serial),
        .o_byte        (w_byte),
        .o_byte_valid  (w_valid),
        .o_framing_err (w_ferr)
    );

    assign bus.ready       = r_ready;
    assign bus.framing_err = w_ferr;
    assign bus.key1_index  = r_key1;
    assign bus.key2_index  = r_key2;

    assign w_note_st = (r_status[7:4] == NOTE_ON) || (r_status[7:4] == NOTE_OFF);
    assign w_ch_ok   = ((r_status[3:0] ^ 4'(CHANNEL)) & CH_MASK) == 4'h0;
    assign w_exec    = w_valid && !w_byte[7] && w_note_st && r_idx && r_note != KEY_EMPTY && w_ch_ok;
    assign w_on      = (r_status[7:4] == NOTE_ON) && w_byte != 8'd0;
    assign w_has     = (r_note == r_key1) || (r_note == r_key2);

    always_comb begin
        w_k1 = r_key1;
        w_k2 = r_key2;
        if (w_on) begin
            if (!w_has) begin
                if (r_key1 == KEY_EMPTY) w_k1 = r_note;
                else w_k2 = r_note;
            end
        end else if (r_key1 == r_note) begin
            w_k1 = r_key2;
            w_k2 = KEY_EMPTY;
        end else if (r_key2 == r_note) begin
            w_k2 = KEY_EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_status <= 8'd0;
            r_idx    <= 1'b0;
            r_note   <= KEY_EMPTY;
            r_key1   <= KEY_EMPTY;
            r_key2   <= KEY_EMPTY;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= w_exec && (w_k1 != r_key1 || w_k2 != r_key2);
            if (w_exec) begin
                r_key1 <= w_k1;
                r_key2 <= w_k2;
            end
            if (w_ferr) begin
                r_status <= 8'd0;
            end else if (w_valid) begin
                // real-time bytes fall through both branches untouched
                if (w_byte[7] && w_byte < SYS_RT_MIN) begin
                    r_status <= (w_byte >= SYS_COM_MIN) ? 8'd0 : w_byte;
                    r_idx    <= 1'b0;
                end else if (!w_byte[7] && w_note_st) begin
                    if (!r_idx) r_note <= w_byte[6:0];
                    r_idx <= !r_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_note_parser.sv
// tb_midi_note_parser: directed MIDI byte streams with hand-computed key states.
module tb_midi_note_parser;
    localparam int BIT = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_cnt = 0;
    int   ferr_cnt = 0;
    int   r0;
    int   f0;

    midi_note_parser_if bus();

    midi_note_parser #(.CLK_HZ(500000), .BAUD(31250), .CHANNEL(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.ready) rdy_cnt++;
        if (bus.framing_err) ferr_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic keys(input string tag, input int k1, input int k2);
        @(negedge clock);
        check({tag, ".key1"}, int'(bus.key1_index), k1);
        check({tag, ".key2"}, int'(bus.key2_index), k2);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok = 1'b1);
        bus.serial = 1'b0;
        repeat (BIT) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.serial = b[i];
            repeat (BIT) @(posedge clock);
        end
        bus.serial = stop_ok;
        repeat (BIT) @(posedge clock);
        bus.serial = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a);
        send(b);
        send(c);
    endtask

    initial begin
        bus.serial = 1'b1;
        repeat (5) @(posedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst.ready", int'(bus.ready), 0);
        check("rst.ferr", int'(bus.framing_err), 0);
        keys("rst", 0, 0);

        r0 = rdy_cnt;
        send3(8'h90, 8'h3C, 8'h64);
        keys("on60", 60, 0);
        check("on60.ready", rdy_cnt - r0, 1);

        r0 = rdy_cnt;
        send(8'h40); send(8'h50);
        keys("rs_on64", 60, 64);
        send(8'h3C); send(8'h00);
        keys("rs_off60", 64, 0);
        check("rs.ready", rdy_cnt - r0, 2);

        r0 = rdy_cnt;
        send(8'h40); send(8'h00);
        keys("off64", 0, 0);
        send3(8'h90, 8'h3C, 8'h64);
        send(8'h40); send(8'h64);
        keys("hold", 60, 64);
        send3(8'h90, 8'h43, 8'h7F);
        keys("replace", 60, 67);
        check("replace.ready", rdy_cnt - r0, 4);

        r0 = rdy_cnt;
        send3(8'h90, 8'h43, 8'h7F);
        keys("dup", 60, 67);
        send3(8'h90, 8'h00, 8'h64);
        keys("note0", 60, 67);
        send3(8'h80, 8'h50, 8'h40);
        keys("off_absent", 60, 67);
        check("nochange.ready", rdy_cnt - r0, 0);

        r0 = rdy_cnt;
        send(8'h90); send(8'h48); send(8'hF8); send(8'h40);
        keys("rt", 60, 72);
        check("rt.ready", rdy_cnt - r0, 1);
        send3(8'hF0, 8'h30, 8'h30);
        keys("sysex", 60, 72);
        check("sysex.ready", rdy_cnt - r0, 1);

        r0 = rdy_cnt;
        f0 = ferr_cnt;
        send(8'h45, 1'b0);
        check("ferr.pulse", ferr_cnt - f0, 1);
        keys("ferr", 60, 72);
        send(8'h3C); send(8'h00);
        keys("ferr_drop", 60, 72);
        check("ferr.ready", rdy_cnt - r0, 0);
        send3(8'h90, 8'h3C, 8'h00);
        keys("vel0_off", 72, 0);
        check("vel0.ready", rdy_cnt - r0, 1);

        bus.serial = 1'b0;
        repeat (5 * BIT + BIT / 2) @(posedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst.ready", int'(bus.ready), 0);
        check("midrst.ferr", int'(bus.framing_err), 0);
        keys("midrst", 0, 0);
        bus.serial = 1'b1;
        repeat (3) @(posedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);

        r0 = rdy_cnt;
        f0 = ferr_cnt;
        send3(8'h90, 8'h3C, 8'h64);
        keys("after_rst", 60, 0);
        send3(8'h80, 8'h3C, 8'h40);
        keys("noteoff", 0, 0);
        check("after_rst.ready", rdy_cnt - r0, 2);
        check("after_rst.ferr", ferr_cnt - f0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
